// File: rtl/multi_iter.sv
// -----------------------------------------------------------------------------
// multi_iter
//   Iterative unsigned multi-precision multiplier. Forms the full
//   2*DATA_WIDTH-bit product of two DATA_WIDTH-bit operands using a single
//   LIMB_WIDTH x LIMB_WIDTH multiplier. The operands are split into
//   NLIMB = DATA_WIDTH/LIMB_WIDTH limbs, and all NLIMB*NLIMB limb pairs are
//   walked schoolbook-style. Each cycle one partial product is added into a
//   shifted accumulator.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     in_valid   in   operands valid
//     in_ready   out  operands can be accepted (IDLE only)
//     dat1       in   multiplicand, unsigned, DATA_WIDTH bits
//     dat2       in   multiplier, unsigned, DATA_WIDTH bits
//     out_valid  out  product valid (DONE)
//     out_ready  in   downstream accepts product
//     product    out  dat1*dat2, 2*DATA_WIDTH bits
//     busy       out  high while in CALC or DONE
// -----------------------------------------------------------------------------
module multi_iter #(
  parameter int DATA_WIDTH = 256,
  parameter int LIMB_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   dat1,
  input  logic [DATA_WIDTH-1:0]   dat2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    busy
);

  localparam int NLIMB = DATA_WIDTH / LIMB_WIDTH;
  localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int LW2   = 2 * LIMB_WIDTH;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMB - 1);

  // A width that does not split into whole limbs would silently drop bits.
  if ((DATA_WIDTH % LIMB_WIDTH) != 0) begin : gBadLimbWidth
    $error("multi_iter: DATA_WIDTH must be a multiple of LIMB_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [IDXW-1:0]       limbI_q, limbI_d;
  logic [IDXW-1:0]       limbJ_q, limbJ_d;

  logic [LIMB_WIDTH-1:0] limbA, limbB;
  logic [LW2-1:0]        partial;
  logic [31:0]           shiftAmt;
  logic [PW-1:0]         partialShifted;

  // The single limb multiplier. Its partial product is widened to the
  // accumulator width and then moved to weight (i+j)*LIMB_WIDTH.
  always_comb begin
    limbA          = op1_q[32'(limbI_q) * LIMB_WIDTH +: LIMB_WIDTH];
    limbB          = op2_q[32'(limbJ_q) * LIMB_WIDTH +: LIMB_WIDTH];
    partial        = LW2'(limbA) * LW2'(limbB);
    shiftAmt       = (32'(limbI_q) + 32'(limbJ_q)) * LIMB_WIDTH;
    partialShifted = PW'(partial) << shiftAmt;
  end

  // Next-state logic. j is the inner index, and i advances when j wraps.
  // The last pair moves the FSM to DONE. acc is deliberately left alone on
  // the DONE->IDLE handshake so that product holds its value while idle.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    acc_d   = acc_q;
    limbI_d = limbI_q;
    limbJ_d = limbJ_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op1_d   = dat1;
          op2_d   = dat2;
          acc_d   = '0;
          limbI_d = '0;
          limbJ_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + partialShifted;
        if (limbJ_q == LAST_IDX) begin
          limbJ_d = '0;
          if (limbI_q == LAST_IDX) begin
            limbI_d = '0;
            state_d = DONE;
          end else begin
            limbI_d = limbI_q + IDXW'(1);
          end
        end else begin
          limbJ_d = limbJ_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      acc_q   <= '0;
      limbI_q <= '0;
      limbJ_q <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      acc_q   <= acc_d;
      limbI_q <= limbI_d;
      limbJ_q <= limbJ_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_multi_iter.sv
// -----------------------------------------------------------------------------
// tb_multi_iter
//   Self-checking bench for multi_iter. It applies a table of directed
//   operand pairs with known products. It then runs hand-written sequences for
//   backpressure, reset mid-operation and input changes during CALC. Finally
//   it applies random operands with random out_ready gaps and checks each
//   result against a plain-arithmetic product model.
// -----------------------------------------------------------------------------
module tb_multi_iter #(
  parameter int DATA_WIDTH = 256,
  parameter int LIMB_WIDTH = 64
);

  localparam int DW         = DATA_WIDTH;
  localparam int PW         = 2 * DATA_WIDTH;
  localparam int NL         = DATA_WIDTH / LIMB_WIDTH;
  localparam int NL2        = NL * NL;
  localparam int BOUND      = NL2 + 40;
  localparam int NUM_RANDOM = 1000;
  localparam int NUM_VECS   = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dat1;
  logic [DW-1:0] dat2;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    string         name;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] prod;
  } vec_t;

  vec_t vecs [NUM_VECS];

  multi_iter #(
    .DATA_WIDTH(DATA_WIDTH),
    .LIMB_WIDTH(LIMB_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dat1     (dat1),
    .dat2     (dat2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The reference model is the exact product of the operands, computed with
  // full-width arithmetic.
  function automatic logic [PW-1:0] refProduct(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Builds a random operand. All-zero and all-one values are deliberately
  // over-represented because they are the arithmetic corner cases.
  function automatic logic [DW-1:0] randOperand();
    logic [DW-1:0] v = '0;
    int sel = $urandom_range(0, 7);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    for (int k = 0; k < (DW + 31) / 32; k++) v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  // Advances to 1 time unit after the next rising edge, where outputs are
  // sampled and inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectorsApplied++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic setVec(input int idx, input string name, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [PW-1:0] prod);
    vecs[idx].name = name;
    vecs[idx].a    = a;
    vecs[idx].b    = b;
    vecs[idx].prod = prod;
  endtask

  // Runs one complete operation. The task offers operands and waits for the
  // accept edge. It then counts edges until out_valid rises. During CALC it
  // can optionally scramble dat1/dat2/in_valid. In DONE it holds out_ready low
  // for 'gap' cycles and checks stability, then performs the out handshake and
  // checks the return to IDLE.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap,
                               input bit scramble, output logic [PW-1:0] got,
                               output int lat, output bit ok);
    int waitCnt;
    ok        = 1'b1;
    lat       = 0;
    got       = '0;
    waitCnt   = 0;
    dat1      = a;
    dat2      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (!in_ready && waitCnt < BOUND) begin
      tick();
      waitCnt++;
    end
    if (!in_ready) begin
      checkValue("in_ready timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      ok       = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < BOUND) begin
      if (scramble) begin
        dat1     = randOperand();
        dat2     = randOperand();
        in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      checkValue("out_valid timeout", int'(out_valid), 1);
      ok = 1'b0;
      return;
    end
    got = product;
    for (int k = 0; k < gap; k++) begin
      tick();
      checkOutput("product stable under backpressure", product, got);
      checkValue("out_valid held under backpressure", int'(out_valid), 1);
      checkValue("in_ready low under backpressure", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkValue("in_ready after out handshake", int'(in_ready), 1);
    checkValue("out_valid after out handshake", int'(out_valid), 0);
    checkOutput("product kept in IDLE", product, got);
  endtask

  initial begin
    logic [PW-1:0] got;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    int            lat;
    bit            ok;
    bit            sawValid;
    int            rstDelay;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dat1      = '0;
    dat2      = '0;
    tick();
    tick();
    checkValue("reset in_ready", int'(in_ready), 1);
    checkValue("reset out_valid", int'(out_valid), 0);
    checkValue("reset busy", int'(busy), 0);
    checkOutput("reset product", product, '0);
    rst = 1'b0;
    tick();

    // Directed vectors. Their products are written out by hand.
    setVec(0, "basic 3*5", DW'(3), DW'(5), PW'(15));
    setVec(1, "zero*max", '0, '1, '0);
    setVec(2, "max*max", '1, '1, {{(DW-1){1'b1}}, 1'b0, {(DW-1){1'b0}}, 1'b1});
    setVec(3, "one*max", DW'(1), '1, {{DW{1'b0}}, {DW{1'b1}}});
    setVec(4, "half*half", DW'(1) << (DW/2), DW'(1) << (DW/2), PW'(1) << DW);
    setVec(5, "max*2", '1, DW'(2), {{(DW-1){1'b0}}, {DW{1'b1}}, 1'b0});

    for (int v = 0; v < NUM_VECS; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, 0, 1'b0, got, lat, ok);
      if (ok) begin
        checkOutput(vecs[v].name, got, vecs[v].prod);
        checkValue({vecs[v].name, " latency"}, lat, NL2);
      end
    end

    // Backpressure: hold out_ready low for 10 cycles while in DONE.
    ra = randOperand();
    rb = randOperand();
    applyStimulus(ra, rb, 10, 1'b0, got, lat, ok);
    if (ok) checkOutput("backpressure product", got, refProduct(ra, rb));

    // Changes to inputs during CALC must be ignored, with a single result.
    ra = DW'(32'hDEAD_BEEF) | (DW'(7) << (DW - 8));
    rb = DW'(32'h1234_5677);
    applyStimulus(ra, rb, 2, 1'b1, got, lat, ok);
    if (ok) begin
      checkOutput("ignore-during-CALC product", got, refProduct(ra, rb));
      checkValue("ignore-during-CALC latency", lat, NL2);
      sawValid = 1'b0;
      for (int k = 0; k < NL2 + 4; k++) begin
        tick();
        sawValid = sawValid | out_valid;
      end
      checkValue("no second out_valid pulse", int'(sawValid), 0);
    end

    // Reset in the middle of CALC discards the operation.
    rstDelay = (NL2 > 7) ? 7 : NL2 - 1;
    dat1     = '1;
    dat2     = '1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkValue("busy after accept", int'(busy), 1);
    for (int k = 0; k < rstDelay; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkValue("mid-op reset in_ready", int'(in_ready), 1);
    checkValue("mid-op reset out_valid", int'(out_valid), 0);
    checkValue("mid-op reset busy", int'(busy), 0);
    checkOutput("mid-op reset product", product, '0);
    sawValid = 1'b0;
    for (int k = 0; k < NL2 + 5; k++) begin
      tick();
      sawValid = sawValid | out_valid;
    end
    checkValue("no out_valid after mid-op reset", int'(sawValid), 0);

    // Random operands and random out_ready gaps checked against the model.
    for (int n = 0; n < NUM_RANDOM; n++) begin
      ra = randOperand();
      rb = randOperand();
      applyStimulus(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), got, lat, ok);
      if (ok) begin
        checkOutput("random product", got, refProduct(ra, rb));
        checkValue("random latency", lat, NL2);
      end else begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
